// File: rtl/sine_period_meter_if.sv
// Sample-stream and measurement-result bundle for the sine period meter.
interface sine_period_meter_if #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned P_WIDTH = 16
) ();

  logic               en;
  logic [D_WIDTH-1:0] din;
  logic [P_WIDTH-1:0] period;
  logic               valid;
  logic               timeout;

  // Sample source side
  modport master (
    output en,
    output din,
    input  period,
    input  valid,
    input  timeout
  );

  // Meter side
  modport slave (
    input  en,
    input  din,
    output period,
    output valid,
    output timeout
  );

endinterface

// File: rtl/sine_period_meter.sv
// Measures the period of a sampled waveform in enabled clock cycles, using
// hysteresis-qualified rising crossings of a mid-level threshold.
module sine_period_meter #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned P_WIDTH = 16,
  parameter int unsigned MID     = 128,
  parameter int unsigned HYST    = 16
) (
  input  logic              clk,
  input  logic              rst,
  sine_period_meter_if.slave bus
);

  localparam logic [D_WIDTH-1:0] Lo     = D_WIDTH'(MID - HYST);
  localparam logic [D_WIDTH-1:0] Hi     = D_WIDTH'(MID + HYST);
  localparam logic [P_WIDTH-1:0] CntMax = {P_WIDTH{1'b1}};

  typedef enum logic [0:0] {StSeekLow, StSeekHigh} state_e;

  state_e             state_q, state_d;
  logic [P_WIDTH-1:0] cnt_q, cnt_d;
  logic [P_WIDTH-1:0] period_q, period_d;
  logic               started_q, started_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               evt;

  // Next-state: crossing detection, period counting and saturation handling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    started_d = started_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    evt       = 1'b0;

    if (bus.en) begin
      case (state_q)
        StSeekLow: begin
          if (bus.din < Lo) state_d = StSeekHigh;
        end
        StSeekHigh: begin
          if (bus.din >= Hi) begin
            evt     = 1'b1;
            state_d = StSeekLow;
          end
        end
        default: state_d = StSeekLow;
      endcase

      if (evt) begin
        timeout_d = 1'b0;
        cnt_d     = P_WIDTH'(1);
        if (started_q) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
        end else begin
          started_d = 1'b1;
        end
      end else if (started_q) begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + P_WIDTH'(1);
        end else begin
          // Counter saturated: abandon this measurement and re-arm from scratch
          timeout_d = 1'b1;
          started_d = 1'b0;
          state_d   = StSeekLow;
          cnt_d     = '0;
        end
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StSeekLow;
      cnt_q     <= '0;
      period_q  <= '0;
      started_q <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      started_q <= started_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.period  = period_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;

endmodule
